// File: rtl/adder_result_reader.sv
// Shadow-captures the segmented adder result and streams it out LSB word first.
// Optional macro ADDER_READER_CARRY_WORD_EN packs carry_in above the sum MSB.
`timescale 1ns/1ps
module adder_result_reader #(
   parameter int WIDTH  = 381,
   parameter int WORD   = 32,
`ifdef ADDER_READER_CARRY_WORD_EN
   parameter int PW     = WIDTH + 1,
`else
   parameter int PW     = WIDTH,
`endif
   parameter int NWORDS = (PW + WORD - 1) / WORD,
   parameter int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             sum_valid,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   output logic             sum_ack,
   output logic [WORD-1:0]  out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    out_index,
   output logic             out_last,
   output logic             busy
);

   localparam int TW = NWORDS * WORD;
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEND  = 2'd1,
      S_REARM = 2'd2
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_shadow;
   logic [IW-1:0]   r_index;
   logic [WORD-1:0] r_data;
   logic            r_valid;
   logic            r_last;
   logic            r_ack;
   logic            r_busy;

   logic [TW-1:0]   w_packed;
   logic [IW-1:0]   w_next;

   always_comb begin
      w_packed = '0;
      w_packed[WIDTH-1:0] = sum_in;
`ifdef ADDER_READER_CARRY_WORD_EN
      w_packed[WIDTH] = carry_in;
`endif
   end

`ifndef ADDER_READER_CARRY_WORD_EN
   logic w_unused_carry;
   assign w_unused_carry = carry_in;
`endif

   assign w_next = r_index + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shadow <= '0;
         r_index  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sum_valid) begin
                  r_shadow <= w_packed;
                  r_index  <= '0;
                  r_data   <= w_packed[WORD-1:0];
                  r_valid  <= 1'b1;
                  r_last   <= (NWORDS == 1);
                  r_ack    <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (r_index == LAST) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_state <= S_REARM;
                  end else begin
                     r_index <= w_next;
                     r_data  <= r_shadow[w_next*WORD +: WORD];
                     r_last  <= (w_next == LAST);
                  end
               end
            end
            // done is sticky upstream; wait for it to drop before rearming
            S_REARM: begin
               if (!sum_valid) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_index <= '0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sum_ack   = r_ack;
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_index = r_index;
   assign out_last  = r_last;
   assign busy      = r_busy;

endmodule

// File: tb/tb_adder_result_reader.sv
// Randomized bench for adder_result_reader against a packed-vector word model.
// Honors ADDER_READER_CARRY_WORD_EN the same way as the design.
`timescale 1ns/1ps
module tb_adder_result_reader;

   logic         clk = 1'b0;
   logic         reset;
   logic         sum_valid;
   logic [380:0] sum_in;
   logic         carry_in;
   logic         sum_ack;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_index;
   logic         out_last;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (sum_ack === 1'b1) ack_cnt++;

   adder_result_reader dut (
      .clk       (clk),
      .reset     (reset),
      .sum_valid (sum_valid),
      .sum_in    (sum_in),
      .carry_in  (carry_in),
      .sum_ack   (sum_ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy)
   );

   function automatic logic [383:0] pack_ref(logic [380:0] s, logic c);
      logic [383:0] p;
      p = 384'(s);
`ifdef ADDER_READER_CARRY_WORD_EN
      p = p | (384'(c) << 381);
`endif
      return p;
   endfunction

   function automatic logic [31:0] ref_word(logic [383:0] p, int k);
      return 32'(p >> (32 * k));
   endfunction

   function automatic logic [380:0] rand_sum();
      logic [383:0] r;
      r = '0;
      for (int k = 0; k < 12; k++) r = (r << 32) | 384'($urandom);
      return 381'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [380:0] s, input logic c);
      sum_in    = s;
      carry_in  = c;
      sum_valid = 1'b1;
      tick();
   endtask

   task automatic collect(input int mode, input int max_hs,
                          output logic [31:0] w [12],
                          output int nhs, output int bad);
      int cyc;
      logic held;
      logic [31:0] hd;
      logic [3:0] hi;
      logic hl;
      cyc = 0; held = 1'b0; nhs = 0; bad = 0;
      hd = '0; hi = '0; hl = 1'b0;
      for (int k = 0; k < 12; k++) w[k] = '0;
      while (nhs < max_hs && cyc < 300) begin
         if (held && (out_valid !== 1'b1 || out_data !== hd ||
                      out_index !== hi || out_last !== hl)) bad++;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid === 1'b1 && out_ready) begin
            if (out_index !== 4'(nhs)) bad++;
            if (out_last !== (nhs == 11)) bad++;
            w[nhs] = out_data;
            nhs++;
            held = 1'b0;
         end else begin
            held = (out_valid === 1'b1);
            hd = out_data; hi = out_index; hl = out_last;
         end
         cyc++;
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sum_valid = 1'b0; sum_in = '0;
      carry_in = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({out_valid, busy, sum_ack, out_last} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {out_valid, busy, sum_ack, out_last});
      end
      checks++;
      if (out_index !== 4'd0 || out_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got idx %0d data %h expected 0/0",
                  out_index, out_data);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy %b valid %b expected 0 0",
                  busy, out_valid);
      end
   endtask

   task automatic test_single_one();
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad, a0;
      logic [31:0] w11;
      a0 = ack_cnt;
      p = pack_ref(381'h1, 1'b1);
      capture(381'h1, 1'b1);
      checks++;
      if ({sum_ack, out_valid, busy} !== 3'b111 || out_index !== 4'd0
          || out_data !== 32'h1) begin
         errors++;
         $display("FAIL first_word: got ack %b valid %b busy %b idx %0d data %h expected 1 1 1 0 00000001",
                  sum_ack, out_valid, busy, out_index, out_data);
      end
      collect(0, 12, w, n, bad);
      checks++;
      if (n !== 12 || bad !== 0) begin
         errors++;
         $display("FAIL single_xfer: got %0d hs %0d protocol faults expected 12 0", n, bad);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (w[k] !== ref_word(p, k)) begin
            errors++;
            $display("FAIL single_word%0d: got %h expected %h", k, w[k], ref_word(p, k));
         end
      end
`ifdef ADDER_READER_CARRY_WORD_EN
      w11 = 32'h2000_0000;
`else
      w11 = 32'h0;
`endif
      checks++;
      if (w[11] !== w11) begin
         errors++;
         $display("FAIL carry_word: got %h expected %h", w[11], w11);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_after_last: got %b expected 0", out_valid);
      end
      sum_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL single_done: got busy %b acks %0d expected 0 1", busy, ack_cnt - a0);
      end
   endtask

   task automatic test_all_ones_stall();
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad;
      p = pack_ref('1, 1'b0);
      capture('1, 1'b0);
      collect(1, 12, w, n, bad);
      checks++;
      if (n !== 12 || bad !== 0) begin
         errors++;
         $display("FAIL stall_xfer: got %0d hs %0d protocol faults expected 12 0", n, bad);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (w[k] !== ref_word(p, k)) begin
            errors++;
            $display("FAIL ones_word%0d: got %h expected %h", k, w[k], ref_word(p, k));
         end
      end
      checks++;
      if (w[11] !== 32'h1FFF_FFFF || w[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL ones_edges: got %h %h expected 1fffffff ffffffff", w[11], w[0]);
      end
      sum_valid = 1'b0;
      tick();
   endtask

   task automatic test_hold_valid();
      logic [380:0] s;
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad, a0;
      a0 = ack_cnt;
      s = rand_sum();
      capture(s, 1'b1);
      collect(2, 12, w, n, bad);
      repeat (5) tick();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL hold_once: got busy %b valid %b acks %0d expected 1 0 1",
                  busy, out_valid, ack_cnt - a0);
      end
      sum_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rearm_idle: got busy %b expected 0", busy);
      end
      s = rand_sum();
      p = pack_ref(s, 1'b0);
      capture(s, 1'b0);
      collect(2, 12, w, n, bad);
      checks++;
      if (n !== 12 || bad !== 0) begin
         errors++;
         $display("FAIL second_xfer: got %0d hs %0d protocol faults expected 12 0", n, bad);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (w[k] !== ref_word(p, k)) begin
            errors++;
            $display("FAIL second_word%0d: got %h expected %h", k, w[k], ref_word(p, k));
         end
      end
      sum_valid = 1'b0;
      tick();
   endtask

   task automatic test_change_mid();
      logic [380:0] s;
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad;
      s = rand_sum();
      p = pack_ref(s, 1'b1);
      capture(s, 1'b1);
      sum_in = ~s;
      carry_in = 1'b0;
      collect(2, 12, w, n, bad);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (w[k] !== ref_word(p, k)) begin
            errors++;
            $display("FAIL shadow_word%0d: got %h expected %h", k, w[k], ref_word(p, k));
         end
      end
      sum_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [380:0] s;
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad;
      s = rand_sum();
      capture(s, 1'b0);
      sum_valid = 1'b0;
      collect(0, 5, w, n, bad);
      checks++;
      if (n !== 5 || out_index !== 4'd5) begin
         errors++;
         $display("FAIL pre_reset: got %0d hs idx %0d expected 5 5", n, out_index);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: got valid %b busy %b idx %0d expected 0 0 0",
                  out_valid, busy, out_index);
      end
      tick();
      reset = 1'b0;
      s = rand_sum();
      p = pack_ref(s, 1'b1);
      capture(s, 1'b1);
      checks++;
      if (out_index !== 4'd0 || out_data !== ref_word(p, 0)) begin
         errors++;
         $display("FAIL restart: got idx %0d data %h expected 0 %h",
                  out_index, out_data, ref_word(p, 0));
      end
      collect(0, 12, w, n, bad);
      checks++;
      if (n !== 12 || bad !== 0 || w[11] !== ref_word(p, 11)) begin
         errors++;
         $display("FAIL restart_xfer: got %0d hs %0d faults w11 %h expected 12 0 %h",
                  n, bad, w[11], ref_word(p, 11));
      end
      sum_valid = 1'b0;
      tick();
   endtask

   task automatic test_valid_at_release();
      logic [380:0] s;
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad;
      reset = 1'b1;
      tick();
      s = rand_sum();
      p = pack_ref(s, 1'b0);
      sum_in = s; carry_in = 1'b0;
      reset = 1'b0;
      sum_valid = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL release_idle: got valid %b busy %b expected 0 0", out_valid, busy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum_ack !== 1'b1 || out_data !== ref_word(p, 0)) begin
         errors++;
         $display("FAIL release_capture: got valid %b ack %b data %h expected 1 1 %h",
                  out_valid, sum_ack, out_data, ref_word(p, 0));
      end
      collect(0, 12, w, n, bad);
      checks++;
      if (n !== 12 || bad !== 0) begin
         errors++;
         $display("FAIL release_xfer: got %0d hs %0d faults expected 12 0", n, bad);
      end
      sum_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [380:0] s;
      logic c;
      logic [383:0] p;
      logic [31:0] w [12];
      int n, bad, a0, wrong;
      for (int t = 0; t < 6; t++) begin
         a0 = ack_cnt;
         s = rand_sum();
         c = 1'($urandom_range(0, 1));
         p = pack_ref(s, c);
         capture(s, c);
         collect(2, 12, w, n, bad);
         sum_valid = 1'b0;
         tick();
         wrong = 0;
         for (int k = 0; k < 12; k++) if (w[k] !== ref_word(p, k)) wrong++;
         checks++;
         if (n !== 12 || bad !== 0 || wrong !== 0 || ack_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL random_xfer%0d: got hs %0d faults %0d bad words %0d acks %0d expected 12 0 0 1",
                     t, n, bad, wrong, ack_cnt - a0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_one();
      test_all_ones_stall();
      test_hold_valid();
      test_change_mid();
      test_reset_mid();
      test_valid_at_release();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
